// File: rtl/enc_cod_reader_pkg.sv
// Shared encoder parameters: symbol geometry, buffer depths and the
// derived codeword length, beat count and beat-counter width.
package enc_cod_reader_pkg;

    localparam int ENC_SYM         = 4;   // symbols per output beat
    localparam int EGF_DIM         = 8;   // bits per symbol
    localparam int ENC_MES_BUF_DEP = 16;  // message symbols, multiple of ENC_SYM
    localparam int ENC_PAR_BUF_DEP = 8;   // parity symbols

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int ENC_COD_LEN = ENC_MES_BUF_DEP + ENC_PAR_BUF_DEP;
    localparam int ENC_OUT_BEA = ceil_div(ENC_COD_LEN, ENC_SYM);
    localparam int ENC_CNT_W   = $clog2(ENC_OUT_BEA + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rd_state_t;

endpackage

// File: rtl/enc_cod_reader.sv
// Codeword reader: captures the message and parity buffers into a shadow
// register and streams the codeword out ENC_SYM symbols per beat,
// earliest symbol in the top lane.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no codeword held, ld_ready=1, out_valid=0
// SEND    | shadow holds a codeword, out_valid=1, top lanes are the beat
module enc_cod_reader
    import enc_cod_reader_pkg::*;
#(
    parameter int SYM_N   = ENC_SYM,
    parameter int SYM_W   = EGF_DIM,
    parameter int MES_DEP = ENC_MES_BUF_DEP,  // must be a multiple of SYM_N
    parameter int PAR_DEP = ENC_PAR_BUF_DEP
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [MES_DEP-1:0][SYM_W-1:0] mes_buf_data,
    input  logic [PAR_DEP-1:0][SYM_W-1:0] par_buf_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SYM_N-1:0][SYM_W-1:0]   out_data,
    output logic                          out_last
);

    localparam int COD_LEN = MES_DEP + PAR_DEP;
    localparam int OUT_BEA = ceil_div(COD_LEN, SYM_N);
    localparam int CNT_W   = $clog2(OUT_BEA + 1);
    // Shadow is padded to whole beats; padding sits below the parity so the
    // final beat's unused low lanes read as zero.
    localparam int PAD_LEN = OUT_BEA * SYM_N;

    rd_state_t                      state, state_nxt;
    logic [CNT_W-1:0]               cnt, cnt_nxt;
    logic [PAD_LEN-1:0][SYM_W-1:0]  shadow;
    logic [PAD_LEN-1:0][SYM_W-1:0]  cap_vec;
    logic [PAD_LEN-1:0][SYM_W-1:0]  shift_vec;
    logic                           do_load;
    logic                           do_shift;
    logic                           is_last;

    assign is_last   = (state == ST_SEND) && (cnt == CNT_W'(OUT_BEA - 1));
    assign out_valid = (state == ST_SEND);
    assign out_last  = is_last;
    assign ld_ready  = (state == ST_IDLE) || (out_ready && is_last);
    assign out_data  = shadow[PAD_LEN-1 -: SYM_N];

    // Arrange the buffers in codeword order: oldest message symbol on top.
    always_comb begin
        cap_vec = '0;
        for (int k = 0; k < MES_DEP; k++) begin
            cap_vec[PAD_LEN-1-k] = mes_buf_data[MES_DEP-1-k];
        end
        for (int j = 0; j < PAR_DEP; j++) begin
            cap_vec[PAD_LEN-1-MES_DEP-j] = par_buf_data[PAR_DEP-1-j];
        end
    end

    // Shadow moved up by one beat, zeros filling from below.
    always_comb begin
        shift_vec = '0;
        for (int i = SYM_N; i < PAD_LEN; i++) begin
            shift_vec[i] = shadow[i-SYM_N];
        end
    end

    // Next state, beat counter and shadow control.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ld_valid) begin
                    state_nxt = ST_SEND;
                    cnt_nxt   = '0;
                    do_load   = 1'b1;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (is_last) begin
                        cnt_nxt = '0;
                        if (ld_valid) begin
                            do_load = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            do_shift  = 1'b1;
                        end
                    end else begin
                        cnt_nxt  = cnt + 1'b1;
                        do_shift = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Shadow register: load on capture, shift up one beat per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (do_load) begin
            shadow <= cap_vec;
        end else if (do_shift) begin
            shadow <= shift_vec;
        end
    end

endmodule

// File: tb/tb_enc_cod_reader.sv
// Directed bench for enc_cod_reader: default geometry (16 message + 8 parity)
// plus a second instance with 6 parity symbols for the padded final beat.
module tb_enc_cod_reader;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  ld_valid, out_ready;
    logic                  ld_valid_b, out_ready_b;
    logic [15:0][7:0]      mes;
    logic [7:0][7:0]       par_a;
    logic [5:0][7:0]       par_b;
    logic                  ld_ready_a, out_valid_a, out_last_a;
    logic [3:0][7:0]       out_data_a;
    logic                  ld_ready_b, out_valid_b, out_last_b;
    logic [3:0][7:0]       out_data_b;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    enc_cod_reader dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready_a),
        .mes_buf_data (mes),
        .par_buf_data (par_a),
        .out_valid    (out_valid_a),
        .out_ready    (out_ready),
        .out_data     (out_data_a),
        .out_last     (out_last_a)
    );

    enc_cod_reader #(.PAR_DEP(6)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid     (ld_valid_b),
        .ld_ready     (ld_ready_b),
        .mes_buf_data (mes),
        .par_buf_data (par_b),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready_b),
        .out_data     (out_data_b),
        .out_last     (out_last_b)
    );

    // Expected beat b: codeword symbol k is bm+k for message, bp+(k-16) for parity.
    function automatic logic [31:0] exp_beat(input int b, input logic [7:0] bm,
                                             input logic [7:0] bp, input int pd);
        logic [31:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            int k;
            logic [7:0] v;
            k = 4 * b + (3 - l);
            if (k < 16)           v = bm + 8'(k);
            else if (k < 16 + pd) v = bp + 8'(k - 16);
            else                  v = 8'h00;
            r[l*8 +: 8] = v;
        end
        return r;
    endfunction

    // Oldest message symbol at index 15, first parity symbol at the top index.
    task automatic set_bufs(input logic [7:0] bm, input logic [7:0] bp);
        for (int i = 0; i < 16; i++) mes[i]   = bm + 8'(15 - i);
        for (int i = 0; i < 8; i++)  par_a[i] = bp + 8'(7 - i);
        for (int i = 0; i < 6; i++)  par_b[i] = bp + 8'(5 - i);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ld_valid = 1'b0; out_ready = 1'b1;
        ld_valid_b = 1'b0; out_ready_b = 1'b1;
        set_bufs(8'h00, 8'h00);
        #3;
        vectors++;
        if ({out_valid_a, out_last_a, ld_ready_a} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_ctrl_a got v/l/r=%b exp 001", {out_valid_a, out_last_a, ld_ready_a});
        end
        vectors++;
        if (out_data_a !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data_a got %h exp 00000000", out_data_a);
        end
        vectors++;
        if ({out_valid_b, out_last_b, ld_ready_b} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_ctrl_b got v/l/r=%b exp 001", {out_valid_b, out_last_b, ld_ready_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid_a !== 1'b0 || ld_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_idle got v=%b r=%b exp v=0 r=1", out_valid_a, ld_ready_a);
        end
    endtask

    task automatic test_stream;
        set_bufs(8'h01, 8'hA1);
        @(negedge clk);
        vectors++;
        if (out_valid_a !== 1'b0 || ld_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_pre got v=%b r=%b exp v=0 r=1", out_valid_a, ld_ready_a);
        end
        ld_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            vectors++;
            if (out_valid_a !== 1'b1 || out_data_a !== exp_beat(b, 8'h01, 8'hA1, 8)) begin
                miscompares++;
                $display("FAIL stream_beat%0d got v=%b d=%h exp v=1 d=%h", b, out_valid_a,
                         out_data_a, exp_beat(b, 8'h01, 8'hA1, 8));
            end
            vectors++;
            if (out_last_a !== (b == 5) || ld_ready_a !== (b == 5)) begin
                miscompares++;
                $display("FAIL stream_last%0d got l=%b r=%b exp %b", b, out_last_a, ld_ready_a, (b == 5));
            end
        end
        @(negedge clk);
        vectors++;
        if (out_valid_a !== 1'b0 || ld_ready_a !== 1'b1 || out_data_a !== 32'h0) begin
            miscompares++;
            $display("FAIL stream_idle got v=%b r=%b d=%h exp v=0 r=1 d=0", out_valid_a, ld_ready_a, out_data_a);
        end
    endtask

    task automatic test_stall;
        int idx;
        int cyc;
        set_bufs(8'h01, 8'hA1);
        @(negedge clk);
        ld_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 6 && cyc < 40) begin
            @(negedge clk);
            vectors++;
            if (out_valid_a !== 1'b1 || out_data_a !== exp_beat(idx, 8'h01, 8'hA1, 8)
                || out_last_a !== (idx == 5)) begin
                miscompares++;
                $display("FAIL stall_cyc%0d got v=%b d=%h l=%b exp beat%0d d=%h", cyc, out_valid_a,
                         out_data_a, out_last_a, idx, exp_beat(idx, 8'h01, 8'hA1, 8));
            end
            out_ready = (cyc % 3 == 0);
            if (out_ready) idx++;
            cyc++;
        end
        vectors++;
        if (idx != 6) begin
            miscompares++;
            $display("FAIL stall_budget got %0d beats exp 6", idx);
        end
        @(negedge clk);
        out_ready = 1'b1;
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle got v=%b exp 0", out_valid_a);
        end
    endtask

    task automatic test_back_to_back;
        set_bufs(8'h01, 8'hA1);
        @(negedge clk);
        ld_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        set_bufs(8'h31, 8'hC1);
        for (int c = 0; c < 12; c++) begin
            logic [7:0] bm, bp;
            bm = (c < 6) ? 8'h01 : 8'h31;
            bp = (c < 6) ? 8'hA1 : 8'hC1;
            @(negedge clk);
            vectors++;
            if (out_valid_a !== 1'b1 || out_data_a !== exp_beat(c % 6, bm, bp, 8)
                || out_last_a !== (c % 6 == 5) || ld_ready_a !== (c % 6 == 5)) begin
                miscompares++;
                $display("FAIL b2b_cyc%0d got v=%b d=%h l=%b r=%b exp d=%h", c, out_valid_a,
                         out_data_a, out_last_a, ld_ready_a, exp_beat(c % 6, bm, bp, 8));
            end
            if (c == 11) ld_valid = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle got v=%b exp 0", out_valid_a);
        end
    endtask

    task automatic test_buffer_change;
        set_bufs(8'h21, 8'hB1);
        @(negedge clk);
        ld_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 16; i++) mes[i]   = 8'($urandom);
            for (int i = 0; i < 8; i++)  par_a[i] = 8'($urandom);
            @(negedge clk);
            vectors++;
            if (out_data_a !== exp_beat(b, 8'h21, 8'hB1, 8)) begin
                miscompares++;
                $display("FAIL bufchg_beat%0d got %h exp %h", b, out_data_a, exp_beat(b, 8'h21, 8'hB1, 8));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        set_bufs(8'h01, 8'hA1);
        @(negedge clk);
        ld_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            vectors++;
            if (out_data_a !== exp_beat(b, 8'h01, 8'hA1, 8)) begin
                miscompares++;
                $display("FAIL rstmid_beat%0d got %h exp %h", b, out_data_a, exp_beat(b, 8'h01, 8'hA1, 8));
            end
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid_a, out_last_a, ld_ready_a} !== 3'b001 || out_data_a !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_async got v/l/r=%b d=%h exp 001 d=0", {out_valid_a, out_last_a, ld_ready_a}, out_data_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (out_valid_a !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_quiet got v=%b exp 0", out_valid_a);
            end
        end
        ld_valid = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid_a !== 1'b1 || out_last_a !== 1'b0 || out_data_a !== exp_beat(0, 8'h01, 8'hA1, 8)) begin
            miscompares++;
            $display("FAIL rstmid_restart got v=%b l=%b d=%h exp v=1 l=0 d=%h", out_valid_a, out_last_a,
                     out_data_a, exp_beat(0, 8'h01, 8'hA1, 8));
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_drain got v=%b exp 0", out_valid_a);
        end
    endtask

    task automatic test_short_par;
        set_bufs(8'h01, 8'hA1);
        @(negedge clk);
        ld_valid_b = 1'b1; out_ready_b = 1'b1;
        @(posedge clk); #1;
        ld_valid_b = 1'b0;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            vectors++;
            if (out_valid_b !== 1'b1 || out_data_b !== exp_beat(b, 8'h01, 8'hA1, 6)
                || out_last_b !== (b == 5)) begin
                miscompares++;
                $display("FAIL shortpar_beat%0d got v=%b d=%h l=%b exp d=%h l=%b", b, out_valid_b,
                         out_data_b, out_last_b, exp_beat(b, 8'h01, 8'hA1, 6), (b == 5));
            end
        end
        @(negedge clk);
        vectors++;
        if (out_valid_b !== 1'b0 || ld_ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL shortpar_idle got v=%b r=%b exp v=0 r=1", out_valid_b, ld_ready_b);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_buffer_change();
        test_reset_mid();
        test_short_par();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/enc_cod_reader.md
ENC_COD_READER -- requirements
Module: enc_cod_reader

Interface
REQ-001 SHALL take parameters from the shared encoder.vh package: ENC_SYM (symbols per beat), EGF_DIM (bits per symbol), ENC_MES_BUF_DEP (message symbols), ENC_PAR_BUF_DEP (parity symbols).
REQ-002 SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ld_valid  in  1  message and parity buffers hold a complete codeword to be captured.
REQ-006 ld_ready  out  1  block accepts a capture this cycle.
REQ-007 mes_buf_data  in  ENC_MES_BUF_DEP x EGF_DIM  message buffer contents; index DEP-1 is the oldest symbol.
REQ-008 par_buf_data  in  ENC_PAR_BUF_DEP x EGF_DIM  parity buffer contents; index DEP-1 is the first parity symbol.
REQ-009 out_valid  out  1  out_data holds a codeword beat.
REQ-010 out_ready  in  1  downstream accepts the beat.
REQ-011 out_data  out  ENC_SYM x EGF_DIM  beat; lane ENC_SYM-1 carries the earliest symbol.
REQ-012 out_last  out  1  current beat is the final beat of the codeword.

Function
REQ-013 Codeword order SHALL be message symbols from mes_buf_data[ENC_MES_BUF_DEP-1] down to [0], then parity symbols from par_buf_data[ENC_PAR_BUF_DEP-1] down to [0]; total ENC_COD_LEN = ENC_MES_BUF_DEP + ENC_PAR_BUF_DEP.
REQ-014 ENC_MES_BUF_DEP SHALL be a multiple of ENC_SYM so that message beats reproduce the writer's input beats exactly; ENC_PAR_BUF_DEP is unconstrained.
REQ-015 Beats per codeword SHALL be ENC_OUT_BEA = ceil(ENC_COD_LEN / ENC_SYM); unused low lanes of the final beat SHALL be zero.
REQ-016 FSM SHALL have two states: IDLE (out_valid=0, ld_ready=1) and SEND (out_valid=1).
REQ-017 A capture (ld_valid & ld_ready) SHALL copy both buffers into an internal shadow register and enter SEND with beat counter 0; first beat valid the next cycle (latency 1).
REQ-018 In SEND, a beat SHALL advance only on out_valid & out_ready; out_data and out_last SHALL remain stable while out_ready=0.
REQ-019 out_last SHALL be 1 exactly when beat counter = ENC_OUT_BEA-1 in SEND.
REQ-020 ld_ready in SEND SHALL equal out_ready & out_last (back-to-back codewords without bubble).
REQ-021 Last-beat acceptance with ld_valid=1 in the same cycle SHALL capture the new codeword, stay in SEND, reset counter to 0; without ld_valid it SHALL return to IDLE.
REQ-022 Input buffer changes after capture SHALL NOT affect the codeword in flight.
REQ-023 Counter width SHALL be $clog2(ENC_OUT_BEA+1); counter never exceeds ENC_OUT_BEA-1.

Reset
REQ-024 rst_n low SHALL force IDLE, counter 0, shadow zero, out_valid=0, out_last=0, out_data=0, ld_ready=1, immediately and regardless of state.
REQ-025 Reset mid-codeword SHALL discard the remainder; no further beats until a new capture.

Structure
REQ-026 ENC_COD_LEN, ENC_OUT_BEA and the counter width SHALL be defined in the shared encoder.vh package next to the buffer depths.
REQ-027 Single module: shadow register shifting up by ENC_SYM symbols per accepted beat, 2-state FSM, beat counter; no sub-module needed.

Verification (ENC_SYM=4, EGF_DIM=8, MES=16, PAR=8, ENC_OUT_BEA=6, unless noted)
REQ-028 Message symbols 0x01..0x10 loaded oldest-first, parity 0xA1..0xA8, out_ready=1 -> 6 consecutive beats starting one cycle after capture, beat0 lanes3..0 = 01,02,03,04; beat5 = A5..A8 with out_last=1.
REQ-029 Same load, out_ready toggled 1,0,0,1,... -> each beat held unchanged during stalls, 6 beats total, no loss or duplication.
REQ-030 ld_valid held high across codewords, out_ready=1 -> second codeword's beat0 in the cycle after first codeword's last beat, 12 beats in 12 cycles.
REQ-031 PAR=6 (22 symbols): final beat lanes3..2 = last two parity symbols, lanes1..0 = 0x00, out_last=1.
REQ-032 rst_n pulsed low during beat 3 -> out_valid=0 at once, IDLE, ld_ready=1; the next capture restarts at beat0.
REQ-033 Buffer inputs changed every cycle after capture -> emitted beats match the values captured.
